// File: rtl/spi_slave_ram.sv
`timescale 1ns/1ps
// SPI slave deserialising 10-bit command frames into a single-port RAM, with read data shifted back on miso.
// Latency: rx_valid on the last frame bit, RAM acts one edge later, miso starts two edges after the frame.
// No backpressure: mosi is ignored while read data is fetched and sent; define SPI_RAM_CLR_EN to zero the RAM on reset.
module spi_slave_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int N         = 10,
    parameter int W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ss_n,
    input  logic         mosi,
    output logic         miso,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic [W-1:0] tx_data,
    output logic         tx_valid
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WAIT,
        SEND
    } state_t;

    localparam int CW = $clog2((N > W ? N : W) + 1);
    localparam logic [CW-1:0] RX_LAST = CW'(N - 1);
    localparam logic [CW-1:0] TX_LAST = CW'(W - 1);
    localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE + 1)'(MEM_DEPTH);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N-2:0]         rx_shift_q, rx_shift_d;
    logic [W-1:0]         tx_shift_q, tx_shift_d;
    logic                 miso_q, miso_d;
    logic [N-1:0]         rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [W-1:0]         tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    logic                 mem_we;
    logic [N-1:0]         frame;
    logic [1:0]           cmd;
    logic                 wr_in_range;
    logic                 rd_in_range;

    // frame is what rx_data would become if the current edge completes it
    assign frame       = {rx_shift_q, mosi};
    assign cmd         = rx_data_q[N-1:N-2];
    assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_LIM);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        miso_d     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ss_n) begin
                    state_d    = RECV;
                    rx_shift_d = frame[N-2:0];
                    cnt_d      = CW'(1);
                end
            end
            RECV: begin
                if (cnt_q == RX_LAST) begin
                    rx_data_d  = frame;
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = (frame[N-1:N-2] == 2'b11) ? WAIT : RECV;
                end else begin
                    rx_shift_d = frame[N-2:0];
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (tx_valid_q) begin
                    state_d    = SEND;
                    miso_d     = tx_data_q[W-1];
                    tx_shift_d = {tx_data_q[W-2:0], 1'b0};
                    cnt_d      = '0;
                end
            end
            SEND: begin
                // MSB already presented at load; W-1 further bits, then one edge to return
                if (cnt_q == TX_LAST) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end else begin
                    miso_d     = tx_shift_q[W-1];
                    tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // deselect aborts whatever the slave was doing, discarding partial frames
        if (ss_n) begin
            state_d    = IDLE;
            cnt_d      = '0;
            miso_d     = 1'b0;
            rx_valid_d = 1'b0;
        end

        if (rx_valid_q) begin
            case (cmd)
                2'b00: wr_addr_d = rx_data_q[ADDR_SIZE-1:0];
                2'b01: mem_we    = wr_in_range;
                2'b10: rd_addr_d = rx_data_q[ADDR_SIZE-1:0];
                default: begin
                    tx_data_d  = rd_in_range ? W'(mem[rd_addr_q]) : '0;
                    tx_valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

`ifdef SPI_RAM_CLR_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[wr_addr_q] <= rx_data_q[MEM_WIDTH-1:0];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= rx_data_q[MEM_WIDTH-1:0];
        end
    end
`endif

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_slave_ram.sv
`timescale 1ns/1ps
// Scoreboard bench for spi_slave_ram: stimulus queues expected frames and read bytes, monitors pop and compare.
module tb_spi_slave_ram;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    always #5 clk = ~clk;

    spi_slave_ram dut (
        .clk      (clk),
        .rst_n    (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [9:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event, value 0x%0h (t=%0t)", name, act, $time);
    endtask

    // rx monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rx_valid) begin
                if (exp_rx.size() == 0) flag("rx_unexpected", 32'(rx_data));
                else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
        end
    end

    // tx monitor: checks tx_data, then collects the following 8 miso bits
    initial begin
        logic [7:0] e;
        logic [7:0] bits;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx_valid) begin
                if (exp_tx.size() == 0) begin
                    flag("tx_unexpected", 32'(tx_data));
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e));
                    bits    = '0;
                    aborted = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        bits = {bits[6:0], miso};
                    end
                    if (!aborted) check("miso_seq", 32'(bits), 32'(e));
                end
            end
        end
    end

    task automatic shift_bits(input logic [9:0] f, input int nbits);
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge clk);
            ss_n = 1'b0;
            mosi = f[i];
        end
    endtask

    task automatic send_frame(input logic [9:0] f);
        exp_rx.push_back(f);
        shift_bits(f, 10);
    endtask

    task automatic read_frame(input logic [7:0] e);
        exp_tx.push_back(e);
        send_frame(10'h300);
        // mosi held high while ignored: any leakage would corrupt the next frame
        repeat (10) begin
            @(negedge clk);
            ss_n = 1'b0;
            mosi = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ss_n = 1'b1;
            mosi = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] post_rst_exp;

        repeat (3) @(negedge clk);
        check("rst_miso",     32'(miso),     32'h0);
        check("rst_rx_data",  32'(rx_data),  32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_tx_data",  32'(tx_data),  32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        rst = 1'b0;
        idle(20);
        check("idle_rx_data", 32'(rx_data), 32'h0);
        check("idle_miso",    32'(miso),    32'h0);

        // write with no address frame lands at address 0
        send_frame(10'h177);
        send_frame(10'h200);
        read_frame(8'h77);
        idle(3);

        // back-to-back write/read
        send_frame(10'h002);
        send_frame(10'h10A);
        send_frame(10'h202);
        read_frame(8'h0A);
        idle(3);

        // top address, then overwrite without a new address frame
        send_frame(10'h0FF);
        send_frame(10'h15A);
        send_frame(10'h2FF);
        read_frame(8'h5A);
        send_frame(10'h1C3);
        read_frame(8'hC3);
        idle(3);

        // abort after 5 bits of a write of 0xFF
        shift_bits(10'h1FF, 5);
        idle(2);
        read_frame(8'hC3);
        idle(2);

        // read address persists
        send_frame(10'h202);
        read_frame(8'h0A);
        idle(2);

`ifdef SPI_RAM_CLR_EN
        send_frame(10'h210);
        read_frame(8'h00);
        idle(2);
`endif

        // reset while shifting out 0xC3
        send_frame(10'h2FF);
        exp_tx.push_back(8'hC3);
        send_frame(10'h300);
        repeat (3) begin
            @(negedge clk);
            ss_n = 1'b0;
            mosi = 1'b1;
        end
        check("miso_pre_rst", 32'(miso), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst_miso",     32'(miso),     32'h0);
        check("midrst_rx_data",  32'(rx_data),  32'h0);
        check("midrst_tx_data",  32'(tx_data),  32'h0);
        check("midrst_tx_valid", 32'(tx_valid), 32'h0);
        repeat (2) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        rst  = 1'b0;
        idle(5);
        check("post_rst_miso",     32'(miso),     32'h0);
        check("post_rst_rx_valid", 32'(rx_valid), 32'h0);

`ifdef SPI_RAM_CLR_EN
        post_rst_exp = 8'h00;
`else
        post_rst_exp = 8'h77;
`endif
        read_frame(post_rst_exp);
        idle(3);

        for (int i = 0; i < 100 && (exp_rx.size() != 0 || exp_tx.size() != 0); i++) @(negedge clk);
        check("rx_queue_left", 32'(exp_rx.size()), 32'h0);
        check("tx_queue_left", 32'(exp_tx.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
